// File: rtl/ahb_lite_master_xactor.sv
// AHB-lite single-transfer master transactor: request FIFO -> address phase -> data phase -> response.
// Handles HREADY wait states and the two-cycle ERROR response by withdrawing and re-issuing the address phase.
module ahb_lite_master_xactor #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            HCLK,
    input  logic                            HRESETn,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_write,
    input  logic [ADDR_W-1:0]               req_addr,
    input  logic [2:0]                      req_size,
    input  logic [DATA_W-1:0]               req_wdata,
    output logic                            rsp_valid,
    output logic [DATA_W-1:0]               rsp_rdata,
    output logic                            rsp_error,
    output logic [$clog2(FIFO_DEPTH+2):0]   outstanding,
    output logic [ADDR_W-1:0]               HADDR,
    output logic                            HWRITE,
    output logic [2:0]                      HSIZE,
    output logic [2:0]                      HBURST,
    output logic [1:0]                      HTRANS,
    output logic [DATA_W-1:0]               HWDATA,
    input  logic                            HREADY,
    input  logic                            HRESP,
    input  logic [DATA_W-1:0]               HRDATA
);

    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int MAX_SIZE = $clog2(DATA_W / 8);

    logic [ADDR_W-1:0] fifo_addr_r  [FIFO_DEPTH];
    logic              fifo_write_r [FIFO_DEPTH];
    logic [2:0]        fifo_size_r  [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_wdata_r [FIFO_DEPTH];
    logic [PTR_W:0]    wptr_r;
    logic [PTR_W:0]    rptr_r;

    logic              ap_valid_r;
    logic [DATA_W-1:0] ap_wdata_r;
    logic              dp_valid_r;
    logic              dp_write_r;
    logic              err_hold_r;

    logic [2:0]        size_clamped_s;
    logic [ADDR_W-1:0] addr_aligned_s;
    logic [PTR_W:0]    fifo_count_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              push_s;
    logic              advance_s;
    logic              complete_s;
    logic              ap_load_s;

    // Request sanitising and pipeline control decisions
    always_comb begin
        if (req_size > 3'(MAX_SIZE)) begin
            size_clamped_s = 3'(MAX_SIZE);
        end else begin
            size_clamped_s = req_size;
        end
        addr_aligned_s = req_addr & ({ADDR_W{1'b1}} << size_clamped_s);
        fifo_count_s   = wptr_r - rptr_r;
        fifo_full_s    = (fifo_count_s == (PTR_W+1)'(FIFO_DEPTH));
        fifo_empty_s   = (wptr_r == rptr_r);
        push_s         = req_valid && !fifo_full_s;
        // During the first ERROR cycle the address phase was withdrawn, so it must not advance.
        advance_s      = HREADY && !err_hold_r;
        complete_s     = dp_valid_r && HREADY;
        ap_load_s      = (!ap_valid_r || advance_s) && !fifo_empty_s;
    end

    assign req_ready = !fifo_full_s;
    assign HBURST    = 3'b000;

    // HTRANS is NONSEQ only for a live, non-withdrawn address phase
    always_comb begin
        if (ap_valid_r && !err_hold_r) begin
            HTRANS = 2'b10;
        end else begin
            HTRANS = 2'b00;
        end
    end

    // Request FIFO storage and pointers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wptr_r <= '0;
            rptr_r <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr_r[i]  <= '0;
                fifo_write_r[i] <= 1'b0;
                fifo_size_r[i]  <= 3'd0;
                fifo_wdata_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                fifo_addr_r[wptr_r[PTR_W-1:0]]  <= addr_aligned_s;
                fifo_write_r[wptr_r[PTR_W-1:0]] <= req_write;
                fifo_size_r[wptr_r[PTR_W-1:0]]  <= size_clamped_s;
                fifo_wdata_r[wptr_r[PTR_W-1:0]] <= req_write ? req_wdata : '0;
                wptr_r <= wptr_r + (PTR_W+1)'(1);
            end
            if (ap_load_s) begin
                rptr_r <= rptr_r + (PTR_W+1)'(1);
            end
        end
    end

    // Address-phase register drives HADDR/HWRITE/HSIZE directly
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ap_valid_r <= 1'b0;
            HADDR      <= '0;
            HWRITE     <= 1'b0;
            HSIZE      <= 3'd0;
            ap_wdata_r <= '0;
        end else if (ap_load_s) begin
            ap_valid_r <= 1'b1;
            HADDR      <= fifo_addr_r[rptr_r[PTR_W-1:0]];
            HWRITE     <= fifo_write_r[rptr_r[PTR_W-1:0]];
            HSIZE      <= fifo_size_r[rptr_r[PTR_W-1:0]];
            ap_wdata_r <= fifo_wdata_r[rptr_r[PTR_W-1:0]];
        end else if (advance_s) begin
            ap_valid_r <= 1'b0;
        end
    end

    // Data-phase register and ERROR withdrawal flag
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid_r <= 1'b0;
            dp_write_r <= 1'b0;
            HWDATA     <= '0;
            err_hold_r <= 1'b0;
        end else begin
            if (advance_s) begin
                dp_valid_r <= ap_valid_r;
                dp_write_r <= HWRITE;
                if (ap_valid_r) begin
                    HWDATA <= ap_wdata_r;
                end
            end else if (complete_s) begin
                dp_valid_r <= 1'b0;
            end
            if (HREADY) begin
                err_hold_r <= 1'b0;
            end else if (dp_valid_r && HRESP) begin
                err_hold_r <= 1'b1;
            end
        end
    end

    // Response generation and outstanding-transfer count
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_error   <= 1'b0;
            outstanding <= '0;
        end else begin
            rsp_valid <= complete_s;
            if (complete_s) begin
                rsp_rdata <= dp_write_r ? '0 : HRDATA;
                rsp_error <= HRESP;
            end else begin
                rsp_error <= 1'b0;
            end
            case ({push_s, complete_s})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_lite_master_xactor.sv
// Directed self-checking bench for ahb_lite_master_xactor with a hand-driven AHB slave.
module tb_ahb_lite_master_xactor;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_error;
    logic [31:0] rsp_rdata;
    logic [3:0]  outstanding;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic        HWRITE, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;
    logic [1:0]  HTRANS;

    int n_checks = 0;
    int n_fail   = 0;

    ahb_lite_master_xactor #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .outstanding(outstanding),
        .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HTRANS(HTRANS), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_req(input logic v, input logic w, input logic [31:0] a,
                           input logic [2:0] s, input logic [31:0] d);
        req_valid = v; req_write = w; req_addr = a; req_size = s; req_wdata = d;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
        set_req(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        tick(); tick();
        n_checks++; if (HTRANS !== 2'b00) begin n_fail++; $display("FAIL reset_htrans: got %0d expected 0", HTRANS); end
        n_checks++; if (HADDR !== 32'h0 || HWDATA !== 32'h0 || HWRITE !== 1'b0 || HSIZE !== 3'd0) begin n_fail++; $display("FAIL reset_bus: HADDR=%h HWDATA=%h HWRITE=%b HSIZE=%0d expected all 0", HADDR, HWDATA, HWRITE, HSIZE); end
        n_checks++; if (rsp_valid !== 1'b0 || rsp_error !== 1'b0 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp: valid=%b err=%b rdata=%h expected 0", rsp_valid, rsp_error, rsp_rdata); end
        n_checks++; if (outstanding !== 4'd0 || req_ready !== 1'b1 || HBURST !== 3'b000) begin n_fail++; $display("FAIL reset_status: outstanding=%0d req_ready=%b HBURST=%0d expected 0/1/0", outstanding, req_ready, HBURST); end
        HRESETn = 1'b1;
        tick();
    endtask

    task automatic test_write_single();
        set_req(1'b1, 1'b1, 32'h0000_0010, 3'd2, 32'hDEAD_BEEF);
        tick();                                   // edge N
        set_req(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        tick();                                   // N+1
        n_checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h10 || HWRITE !== 1'b1 || HSIZE !== 3'd2) begin n_fail++; $display("FAIL wr_addr_phase: HTRANS=%0d HADDR=%h HWRITE=%b HSIZE=%0d expected 2/10/1/2", HTRANS, HADDR, HWRITE, HSIZE); end
        n_checks++; if (outstanding !== 4'd1) begin n_fail++; $display("FAIL wr_outstanding: got %0d expected 1", outstanding); end
        tick();                                   // N+2
        n_checks++; if (HWDATA !== 32'hDEAD_BEEF || HTRANS !== 2'b00) begin n_fail++; $display("FAIL wr_data_phase: HWDATA=%h HTRANS=%0d expected deadbeef/0", HWDATA, HTRANS); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_early: got %b expected 0", rsp_valid); end
        tick();                                   // N+3
        n_checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL wr_rsp: valid=%b err=%b rdata=%h expected 1/0/0", rsp_valid, rsp_error, rsp_rdata); end
        n_checks++; if (outstanding !== 4'd0) begin n_fail++; $display("FAIL wr_outstanding_end: got %0d expected 0", outstanding); end
        tick();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_pulse: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_read_waits();
        set_req(1'b1, 1'b0, 32'h0000_0020, 3'd2, 32'h0);
        tick();                                   // N
        set_req(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        tick();                                   // N+1
        n_checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h20 || HWRITE !== 1'b0) begin n_fail++; $display("FAIL rd_addr_phase: HTRANS=%0d HADDR=%h HWRITE=%b expected 2/20/0", HTRANS, HADDR, HWRITE); end
        tick();                                   // N+2: data phase, slave waits
        HREADY = 1'b0;
        tick();                                   // N+3
        n_checks++; if (HADDR !== 32'h20 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_wait1: HADDR=%h rsp_valid=%b expected 20/0", HADDR, rsp_valid); end
        tick();                                   // N+4
        n_checks++; if (HADDR !== 32'h20 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_wait2: HADDR=%h rsp_valid=%b expected 20/0", HADDR, rsp_valid); end
        HREADY = 1'b1; HRDATA = 32'h1234_5678;
        tick();                                   // N+5
        HRDATA = 32'h0;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678 || rsp_error !== 1'b0) begin n_fail++; $display("FAIL rd_rsp: valid=%b rdata=%h err=%b expected 1/12345678/0", rsp_valid, rsp_rdata, rsp_error); end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 8; c++) begin
            if (c < 4) set_req(1'b1, 1'b1, 32'(4 * c), 3'd2, 32'hA000_0000 + 32'(c));
            else       set_req(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
            tick();                               // edge E_c
            if (c >= 1 && c <= 4) begin
                n_checks++; if (HTRANS !== 2'b10 || HADDR !== 32'(4 * (c - 1))) begin n_fail++; $display("FAIL b2b_nonseq[%0d]: HTRANS=%0d HADDR=%h expected 2/%h", c, HTRANS, HADDR, 4 * (c - 1)); end
            end
            if (c >= 2 && c <= 5) begin
                n_checks++; if (HWDATA !== 32'hA000_0000 + 32'(c - 2)) begin n_fail++; $display("FAIL b2b_hwdata[%0d]: got %h expected %h", c, HWDATA, 32'hA000_0000 + 32'(c - 2)); end
            end
            if (c >= 3 && c <= 6) begin
                n_checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0) begin n_fail++; $display("FAIL b2b_rsp[%0d]: valid=%b err=%b expected 1/0", c, rsp_valid, rsp_error); end
            end
            if (c == 7) begin
                n_checks++; if (rsp_valid !== 1'b0 || HTRANS !== 2'b00 || outstanding !== 4'd0) begin n_fail++; $display("FAIL b2b_end: valid=%b HTRANS=%0d outstanding=%0d expected 0/0/0", rsp_valid, HTRANS, outstanding); end
            end
        end
    endtask

    task automatic test_error();
        set_req(1'b1, 1'b0, 32'h40, 3'd2, 32'h0);
        tick();                                   // E0
        set_req(1'b1, 1'b1, 32'h44, 3'd2, 32'hCAFE_0044);
        tick();                                   // E1
        set_req(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        tick();                                   // E2: read in data phase, write in address phase
        n_checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h44) begin n_fail++; $display("FAIL err_pre: HTRANS=%0d HADDR=%h expected 2/44", HTRANS, HADDR); end
        HRESP = 1'b1; HREADY = 1'b0;
        tick();                                   // E3: second error cycle
        n_checks++; if (HTRANS !== 2'b00 || HADDR !== 32'h44 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL err_withdraw: HTRANS=%0d HADDR=%h rsp_valid=%b expected 0/44/0", HTRANS, HADDR, rsp_valid); end
        HREADY = 1'b1;
        tick();                                   // E4
        HRESP = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1) begin n_fail++; $display("FAIL err_rsp: valid=%b err=%b expected 1/1", rsp_valid, rsp_error); end
        n_checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h44 || HWRITE !== 1'b1) begin n_fail++; $display("FAIL err_reissue: HTRANS=%0d HADDR=%h HWRITE=%b expected 2/44/1", HTRANS, HADDR, HWRITE); end
        tick();                                   // E5
        n_checks++; if (HWDATA !== 32'hCAFE_0044 || rsp_valid !== 1'b0 || HTRANS !== 2'b00) begin n_fail++; $display("FAIL err_wr_data: HWDATA=%h rsp_valid=%b HTRANS=%0d expected cafe0044/0/0", HWDATA, rsp_valid, HTRANS); end
        tick();                                   // E6
        n_checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || outstanding !== 4'd0) begin n_fail++; $display("FAIL err_wr_rsp: valid=%b err=%b outstanding=%0d expected 1/0/0", rsp_valid, rsp_error, outstanding); end
        tick();
    endtask

    task automatic test_fifo_full();
        int acc = 0;
        int ns  = 1;
        int rc  = 0;
        HREADY = 1'b0;
        for (int c = 0; c < 10; c++) begin
            logic rdy;
            set_req(1'b1, 1'b1, 32'h100 + 32'(4 * acc), 3'd2, 32'(acc));
            rdy = req_ready;
            tick();
            if (rdy) acc++;
        end
        set_req(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        n_checks++; if (acc != 5 || req_ready !== 1'b0) begin n_fail++; $display("FAIL full_accepts: accepted=%0d req_ready=%b expected 5/0", acc, req_ready); end
        n_checks++; if (outstanding !== 4'd5) begin n_fail++; $display("FAIL full_outstanding: got %0d expected 5", outstanding); end
        n_checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h100) begin n_fail++; $display("FAIL full_hold: HTRANS=%0d HADDR=%h expected 2/100", HTRANS, HADDR); end
        HREADY = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (rsp_valid === 1'b1) rc++;
            if (HTRANS === 2'b10) begin
                n_checks++; if (HADDR !== 32'h100 + 32'(4 * ns)) begin n_fail++; $display("FAIL drain_order: HADDR=%h expected %h", HADDR, 32'h100 + 32'(4 * ns)); end
                ns++;
            end
        end
        n_checks++; if (ns != 5 || rc != 5) begin n_fail++; $display("FAIL drain_count: issued=%0d responses=%0d expected 5/5", ns, rc); end
        n_checks++; if (outstanding !== 4'd0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL drain_end: outstanding=%0d req_ready=%b expected 0/1", outstanding, req_ready); end
    endtask

    task automatic test_align_and_flush();
        int rc = 0;
        set_req(1'b1, 1'b0, 32'h13, 3'd2, 32'h0);
        tick();                                   // E0
        set_req(1'b1, 1'b1, 32'h26, 3'd3, 32'h5555_AAAA);
        tick();                                   // E1
        n_checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h10 || HSIZE !== 3'd2) begin n_fail++; $display("FAIL align_addr: HTRANS=%0d HADDR=%h HSIZE=%0d expected 2/10/2", HTRANS, HADDR, HSIZE); end
        set_req(1'b1, 1'b0, 32'h80, 3'd2, 32'h0);
        tick();                                   // E2
        n_checks++; if (HADDR !== 32'h24 || HSIZE !== 3'd2) begin n_fail++; $display("FAIL clamp_size: HADDR=%h HSIZE=%0d expected 24/2", HADDR, HSIZE); end
        HRESETn = 1'b0;
        #1;
        n_checks++; if (HTRANS !== 2'b00 || HADDR !== 32'h0 || HWDATA !== 32'h0 || HSIZE !== 3'd0) begin n_fail++; $display("FAIL flush_bus: HTRANS=%0d HADDR=%h HWDATA=%h HSIZE=%0d expected all 0", HTRANS, HADDR, HWDATA, HSIZE); end
        n_checks++; if (outstanding !== 4'd0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_status: outstanding=%0d req_ready=%b rsp_valid=%b expected 0/1/0", outstanding, req_ready, rsp_valid); end
        set_req(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        tick();
        HRESETn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (rsp_valid === 1'b1 || HTRANS !== 2'b00) rc++;
        end
        n_checks++; if (rc != 0 || outstanding !== 4'd0) begin n_fail++; $display("FAIL flush_quiet: activity cycles=%0d outstanding=%0d expected 0/0", rc, outstanding); end
    endtask

    initial begin
        test_reset();
        test_write_single();
        test_read_waits();
        test_back_to_back();
        test_error();
        test_fifo_full();
        test_align_and_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_lite_master_xactor.md
# ahb_lite_master_xactor

Synthesizable AHB-lite master transactor in the emulator-side HDL top. It sits directly upstream of the AHB-lite DUT on the AHB interface and is driven by HVL-side transactions through a request FIFO. It converts each request into a single AHB-lite transfer with pipelined address and data phases, honours HREADY wait states and two-cycle ERROR responses, and returns one response per request.

## Interface
- ADDR_W, 32: HADDR and request address width.
- DATA_W, 32: HWDATA/HRDATA width. Legal values are 8, 16, 32 and 64.
- FIFO_DEPTH, 4: request FIFO entries. Must be a power of 2 and at least 2.

Ports:
- HCLK  in  1  system clock; all logic is rising-edge.
- HRESETn  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  equals !fifo_full.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_size  in  3  HSIZE encoding.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle pulse when a transfer completes.
- rsp_rdata  out  DATA_W  captured HRDATA; 0 for writes.
- rsp_error  out  1  HRESP was ERROR for this transfer.
- outstanding  out  $clog2(FIFO_DEPTH+2)+1  count of FIFO entries plus the address-phase transfer plus the data-phase transfer.
- HADDR  out  ADDR_W;  HWRITE  out  1;  HSIZE  out  3;  HBURST  out  3, tied to 3'b000 (SINGLE);  HTRANS  out  2;  HWDATA  out  DATA_W.
- HREADY  in  1;  HRESP  in  1;  HRDATA  in  DATA_W.

## Operation
- Request FIFO: a request is accepted when req_valid && req_ready. There is no bypass, so a push while the FIFO is full is refused even if a pop happens in the same cycle.
- Request sanitising at push:
  - req_size is clamped to log2(DATA_W/8).
  - The low req_size address bits are cleared to force alignment.
- Address-phase register (AP) holds the transfer currently on HADDR/HTRANS. The data-phase register (DP) holds the write data and the read/write flag of the transfer in its data phase.
- AP loads the FIFO head when AP is empty, or when AP is being accepted (HREADY=1), and the FIFO is non-empty. HTRANS is NONSEQ while AP is valid and IDLE (2'b00) otherwise. BUSY and SEQ are never driven.
- Pipeline advance on a clock edge with HREADY=1:
  - AP moves to DP.
  - The previous DP completes.
  - HWDATA is driven from DP throughout the data phase and is held through wait states.
- Completion, on the edge where DP is valid and HREADY=1:
  - rsp_valid=1 the next cycle.
  - rsp_rdata = HRDATA for reads, 0 for writes.
  - rsp_error = HRESP.
- ERROR handling:
  - First ERROR cycle (HRESP=1, HREADY=0): AP is withdrawn and HTRANS is forced to IDLE on the next cycle. AP contents are kept.
  - Second cycle (HRESP=1, HREADY=1): completes DP with rsp_error=1.
  - The withdrawn AP is re-issued as NONSEQ in the cycle after the error completes. Transfers are never dropped and never reordered.
- Address-phase signals of an AP transfer stay stable while HREADY=0, except for the ERROR withdrawal.

## Timing
- Reset values:
  - HTRANS=IDLE; HADDR, HWRITE, HSIZE, HWDATA = 0.
  - rsp_valid, rsp_error, rsp_rdata = 0.
  - outstanding=0; req_ready=1.
- HRESETn assertion at any time empties the FIFO, AP and DP. In-flight transfers are discarded with no response. Outputs return to reset values asynchronously.
- Latency with zero wait states, request accepted at edge N:
  - NONSEQ is on the bus in cycle N+1.
  - Data phase is cycle N+2.
  - rsp_valid is in cycle N+3.
- Each HREADY=0 cycle adds one cycle of latency. An ERROR adds the extra error cycle plus the re-issue cycle for the following transfer.
- Throughput is one transfer per cycle when back-to-back with HREADY=1.
- outstanding increments on push, decrements on completion, and is unchanged when both happen in the same cycle.

## Test plan
- Write 0x0000_0010 <= 0xDEAD_BEEF, size 2, HREADY=1 -> NONSEQ in N+1, HWDATA=0xDEADBEEF in N+2, rsp_valid in N+3 with rsp_error=0 and rsp_rdata=0.
- Read 0x20, size 2, slave inserts 2 waits, HRDATA=0x1234_5678 -> HADDR stable across the waits, rsp_valid at N+5 with rsp_rdata=0x12345678.
- Four back-to-back writes to 0x0, 0x4, 0x8, 0xC with HREADY=1 -> four consecutive NONSEQ cycles and four consecutive rsp_valid pulses, in order.
- Read 0x40, then write 0x44; slave ERRORs the read -> HTRANS=IDLE in the second error cycle, rsp_error=1 for the read, the write is re-issued and completes with rsp_error=0.
- HREADY held 0 while pushing -> req_ready drops after FIFO_DEPTH+1 accepts (FIFO_DEPTH FIFO entries plus one in AP) and outstanding=FIFO_DEPTH+1. Releasing HREADY drains all transfers in order.
- Push size 2 to address 0x13, then assert HRESETn=0 mid-burst -> the first request is issued as HADDR=0x10. After reset, outputs are at reset values, outstanding=0, and no rsp_valid is produced for flushed entries.
